fetch_unit: RTL and testbench

//  Instruction-fetch front end: owns the PC, prefetches over a req/ack instruction-memory port into a small queue, and drives the IF/ID register.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 71 +++++++
 rtl/fetch_unit.sv | 202 ++++++++++++++++++++
 tb/tb_fetch_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// The optional FETCH_PERF_EN build adds performance counters in fetch_unit.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_FULL    = 2'd2,
      ST_DISCARD = 2'd3
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
   localparam logic [31:0] PC_STEP           = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small {pc,instr} prefetch FIFO; DEPTH must be a power of two.
// Clear wins over push; push and pop together are legal even when full.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = AW + 1
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         clear,
   output fetch_entry_t head,
   output logic         full,
   output logic         empty,
   output logic [CW-1:0] count
);

   localparam logic [AW-1:0] PTR_MASK = AW'(DEPTH - 1);

   fetch_entry_t  mem_reg [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          push_ok;
   logic          pop_ok;
   logic [DEPTH-1:0] wr_en;

   assign empty = (count_reg == '0);
   assign full  = (count_reg == CW'(DEPTH));
   assign count = count_reg;
   assign head  = mem_reg[rd_ptr_reg];

   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
         assign wr_en[gi] = push_ok & ~clear & (wr_ptr_reg == AW'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_en[i]) begin
            mem_reg[i] <= push_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (srst || clear) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= (wr_ptr_reg + 1'b1) & PTR_MASK;
         end
         if (pop_ok) begin
            rd_ptr_reg <= (rd_ptr_reg + 1'b1) & PTR_MASK;
         end
         count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC, req/ack prefetch into fetch_queue, IF/ID register.
// Define FETCH_PERF_EN to add saturating stall/flush performance counters.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int          DEPTH     = 2,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        PCWrite_i,
   input  logic        Stall_i,
   input  logic        flush_i,
   input  logic [31:0] branch_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        valid_o
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_stall_cnt_o,
   output logic [31:0] perf_flush_cnt_o
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   fetch_state_t  state_reg, state_next;
   logic [31:0]   fetch_pc_reg, fetch_pc_next;
   logic [31:0]   addr_hold_reg, addr_hold_next;
   logic [31:0]   instr_reg;
   logic [31:0]   pc_reg;
   logic          valid_reg;

   fetch_entry_t  q_head;
   fetch_entry_t  q_push_data;
   logic          q_full;
   logic          q_empty;
   logic [CW-1:0] q_count;
   logic          q_push;
   logic          q_pop;

   logic          hold;
   logic          in_fetch;
   logic          accept;
   logic          if_load;
   logic          bypass;
   logic          full_after;

   assign hold     = Stall_i | ~PCWrite_i;
   assign in_fetch = (state_reg == ST_FETCH);
   assign accept   = in_fetch & imem_ack_i & ~flush_i;
   assign if_load  = ~flush_i & ~hold;

   // An ack into an empty queue goes straight to IF/ID, giving one-cycle latency.
   assign bypass   = accept & if_load & q_empty;
   assign q_push   = accept & ~bypass;
   assign q_pop    = if_load & ~q_empty;

   assign q_push_data = '{pc: fetch_pc_reg, instr: imem_data_i};

   assign full_after = (q_full & (q_push | ~q_pop)) |
                       (~q_full & q_push & ~q_pop & (q_count == CW'(DEPTH - 1)));

   fetch_queue #(
      .DEPTH(DEPTH)
   ) u_queue (
      .clk       (clk_i),
      .srst      (rst_i),
      .push      (q_push),
      .push_data (q_push_data),
      .pop       (q_pop),
      .clear     (flush_i),
      .head      (q_head),
      .full      (q_full),
      .empty     (q_empty),
      .count     (q_count)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg     <= ST_IDLE;
         fetch_pc_reg  <= RESET_PC;
         addr_hold_reg <= RESET_PC;
      end else begin
         state_reg     <= state_next;
         fetch_pc_reg  <= fetch_pc_next;
         addr_hold_reg <= addr_hold_next;
      end
   end

   // In DISCARD the bus must keep showing the address of the abandoned request.
   assign imem_addr_o    = in_fetch ? fetch_pc_reg : addr_hold_reg;
   assign addr_hold_next = imem_addr_o;

   always_comb begin
      state_next    = state_reg;
      fetch_pc_next = fetch_pc_reg;
      imem_req_o    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (flush_i) begin
               fetch_pc_next = branch_target_i;
            end
            if (start_i) begin
               state_next = ST_FETCH;
            end
         end
         ST_FETCH: begin
            imem_req_o = 1'b1;
            if (flush_i) begin
               fetch_pc_next = branch_target_i;
               if (!imem_ack_i) begin
                  state_next = ST_DISCARD;
               end
            end else if (imem_ack_i) begin
               fetch_pc_next = next_pc(fetch_pc_reg);
               if (full_after) begin
                  state_next = ST_FULL;
               end
            end
         end
         ST_FULL: begin
            if (flush_i) begin
               fetch_pc_next = branch_target_i;
               state_next    = ST_FETCH;
            end else if (q_pop) begin
               state_next = ST_FETCH;
            end
         end
         ST_DISCARD: begin
            imem_req_o = 1'b1;
            if (flush_i) begin
               fetch_pc_next = branch_target_i;
            end
            if (imem_ack_i) begin
               state_next = ST_FETCH;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         instr_reg <= NOP_INSTR;
         pc_reg    <= '0;
         valid_reg <= 1'b0;
      end else if (flush_i) begin
         instr_reg <= NOP_INSTR;
         valid_reg <= 1'b0;
      end else if (!hold) begin
         if (!q_empty) begin
            instr_reg <= q_head.instr;
            pc_reg    <= q_head.pc;
            valid_reg <= 1'b1;
         end else if (bypass) begin
            instr_reg <= imem_data_i;
            pc_reg    <= fetch_pc_reg;
            valid_reg <= 1'b1;
         end else begin
            instr_reg <= NOP_INSTR;
            valid_reg <= 1'b0;
         end
      end
   end

   assign instr_o = instr_reg;
   assign pc_o    = pc_reg;
   assign valid_o = valid_reg;

`ifdef FETCH_PERF_EN
   logic [31:0] perf_stall_reg;
   logic [31:0] perf_flush_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_stall_reg <= '0;
         perf_flush_reg <= '0;
      end else begin
         if (valid_reg && Stall_i && (perf_stall_reg != 32'hFFFF_FFFF)) begin
            perf_stall_reg <= perf_stall_reg + 32'd1;
         end
         if (flush_i && (perf_flush_reg != 32'hFFFF_FFFF)) begin
            perf_flush_reg <= perf_flush_reg + 32'd1;
         end
      end
   end

   assign perf_stall_cnt_o = perf_stall_reg;
   assign perf_flush_cnt_o = perf_flush_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model, IF/ID scoreboard, directed scenarios.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] TB_NOP      = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        start;
   logic        pcwrite;
   logic        stall;
   logic        flush;
   logic [31:0] target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        valid;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_stall;
   logic [31:0] perf_flush;
`endif

   fetch_unit #(
      .DEPTH     (2),
      .RESET_PC  (TB_RESET_PC),
      .NOP_INSTR (TB_NOP)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .start_i         (start),
      .PCWrite_i       (pcwrite),
      .Stall_i         (stall),
      .flush_i         (flush),
      .branch_target_i (target),
      .imem_req_o      (imem_req),
      .imem_addr_o     (imem_addr),
      .imem_ack_i      (imem_ack),
      .imem_data_i     (imem_data),
      .instr_o         (instr),
      .pc_o            (pc),
      .valid_o         (valid)
`ifdef FETCH_PERF_EN
      ,
      .perf_stall_cnt_o (perf_stall),
      .perf_flush_cnt_o (perf_flush)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5C3_0001;
   endfunction

   // Memory model: acks mem_lat cycles after seeing a request; stray injects an unsolicited ack.
   bit          mem_en;
   int          mem_lat;
   int          mem_wait;
   bit          stray;
   bit          ack_stray;
   logic [31:0] ack_addr;

   initial begin
      imem_ack  = 1'b0;
      imem_data = '0;
      ack_stray = 1'b0;
      ack_addr  = '0;
      mem_wait  = 0;
      forever begin
         @(negedge clk);
         imem_ack  = 1'b0;
         ack_stray = 1'b0;
         if (stray) begin
            imem_ack  = 1'b1;
            ack_stray = 1'b1;
            imem_data = 32'hBAD0_BAD0;
         end else if (mem_en && imem_req && !rst) begin
            if (mem_wait >= mem_lat) begin
               imem_ack  = 1'b1;
               ack_addr  = imem_addr;
               imem_data = mem_word(imem_addr);
               mem_wait  = 0;
            end else begin
               mem_wait++;
            end
         end else begin
            mem_wait = 0;
         end
      end
   end

   // Reference model of fetch PC and IF/ID, updated once per clock from the driven inputs.
   fetch_entry_t sb[$];
   logic [31:0]  exp_instr;
   logic [31:0]  exp_pc;
   logic         exp_valid;
   logic [31:0]  exp_fpc;
   bit           discard_pending;
   bit           flush_discard;
   int           exp_stall_cnt;
   int           exp_flush_cnt;

   initial begin
      fetch_entry_t e;
      exp_instr = TB_NOP;
      exp_pc    = '0;
      exp_valid = 1'b0;
      exp_fpc   = TB_RESET_PC;
      discard_pending = 1'b0;
      exp_stall_cnt = 0;
      exp_flush_cnt = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            sb.delete();
            exp_instr = TB_NOP;
            exp_pc    = '0;
            exp_valid = 1'b0;
            exp_fpc   = TB_RESET_PC;
            discard_pending = 1'b0;
            exp_stall_cnt = 0;
            exp_flush_cnt = 0;
         end else begin
            if (exp_valid && stall) exp_stall_cnt++;
            if (flush) exp_flush_cnt++;
            if (imem_ack && !ack_stray) begin
               if (discard_pending) begin
                  discard_pending = 1'b0;
               end else if (!flush) begin
                  check_eq("ack_addr", ack_addr, exp_fpc);
                  e.pc    = exp_fpc;
                  e.instr = mem_word(exp_fpc);
                  sb.push_back(e);
                  exp_fpc = exp_fpc + 32'd4;
               end
            end
            if (flush) begin
               sb.delete();
               exp_fpc = target;
               if (flush_discard) discard_pending = 1'b1;
               exp_instr = TB_NOP;
               exp_valid = 1'b0;
            end else if (!(stall || !pcwrite)) begin
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  exp_instr = e.instr;
                  exp_pc    = e.pc;
                  exp_valid = 1'b1;
               end else begin
                  exp_instr = TB_NOP;
                  exp_valid = 1'b0;
               end
            end
         end
         #1;
         check_eq("ifid_valid", 32'(valid), 32'(exp_valid));
         check_eq("ifid_instr", instr, exp_instr);
         check_eq("ifid_pc", pc, exp_pc);
         $display("cycle t=%0t ack=%0b flush=%0b hold=%0b valid=%0b pc=%h instr=%h",
                  $time, imem_ack, flush, (stall || !pcwrite), valid, pc, instr);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Park the memory so a request is outstanding and the queue has drained.
   task automatic park_request();
      mem_en = 1'b0;
      step(3);
      check_eq("park_req", 32'(imem_req), 32'd1);
   endtask

   task automatic do_flush(input logic [31:0] tgt, input bit discard);
      flush = 1'b1;
      target = tgt;
      flush_discard = discard;
      step(1);
      flush = 1'b0;
      flush_discard = 1'b0;
   endtask

   logic [31:0] stale;

   initial begin
      rst = 1'b1; start = 1'b0; pcwrite = 1'b1; stall = 1'b0;
      flush = 1'b0; target = '0; flush_discard = 1'b0;
      mem_en = 1'b1; mem_lat = 1; stray = 1'b0;
      step(3);
      check_eq("rst_req", 32'(imem_req), 32'd0);
      check_eq("rst_addr", imem_addr, TB_RESET_PC);

      // Sequential fetch from reset PC
      rst = 1'b0; start = 1'b1;
      step(10);

      // Hold IF/ID until the queue fills and requests stop
      stall = 1'b1; pcwrite = 1'b0;
      step(3);
      stall = 1'b0;
      step(5);
      check_eq("full_req", 32'(imem_req), 32'd0);
      pcwrite = 1'b1;
      step(10);

      // Flush while a request is outstanding: its data is discarded
      park_request();
      stale = exp_fpc;
      do_flush(32'h0000_0100, 1'b1);
      check_eq("discard_req", 32'(imem_req), 32'd1);
      check_eq("discard_addr", imem_addr, stale);
      mem_en = 1'b1;
      step(10);

      // Flush coinciding with the ack
      park_request();
      mem_en = 1'b1; mem_lat = 0;
      do_flush(32'h0000_0200, 1'b0);
      mem_lat = 1;
      check_eq("flush_ack_addr", imem_addr, 32'h0000_0200);
      check_eq("flush_ack_req", 32'(imem_req), 32'd1);
      step(8);

      // PC wrap at top of address space
      park_request();
      do_flush(32'hFFFF_FFFC, 1'b1);
      mem_en = 1'b1;
      step(10);

      // Reset during an outstanding request, then an unsolicited ack in IDLE
      park_request();
      start = 1'b0; rst = 1'b1;
      step(1);
      check_eq("rst_mid_req", 32'(imem_req), 32'd0);
      rst = 1'b0; stray = 1'b1;
      step(1);
      stray = 1'b0;
      check_eq("stray_req", 32'(imem_req), 32'd0);
      check_eq("stray_valid", 32'(valid), 32'd0);
      mem_en = 1'b1; start = 1'b1;
      step(8);

      // Five stalled cycles with a valid instruction, then two flushes
      for (int i = 0; i < 10 && !exp_valid; i++) step(1);
      check_eq("stall_valid", 32'(valid), 32'd1);
      stall = 1'b1;
      step(5);
      stall = 1'b0;
      mem_en = 1'b0;
      step(3);
      check_eq("perf_park_req", 32'(imem_req), 32'd1);
      do_flush(32'h0000_0300, 1'b1);
      do_flush(32'h0000_0400, 1'b1);
      mem_en = 1'b1;
      step(8);
`ifdef FETCH_PERF_EN
      check_eq("perf_stall", perf_stall, 32'(exp_stall_cnt));
      check_eq("perf_flush", perf_flush, 32'(exp_flush_cnt));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
